// File: rtl/miner_pkg.sv
// Shared definitions for the miner job path.
// Holds header geometry constants and the header loader state encoding.
package miner_pkg;

   localparam int HDR_WORDS  = 20;
   localparam int BLK1_WORDS = 16;
   localparam int TAIL_WORDS = 3;
   localparam int NONCE_IDX  = 19;
   localparam int IDX_W      = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      PEND = 2'd2
   } loader_state_e;

endpackage

// File: rtl/miner_bswap32.sv
// Purely combinational 32-bit byte reverser.
// Ports:
//   data_i : input word, byte 0 at [7:0]
//   data_o : same word with byte order reversed
module miner_bswap32 (
   input  logic [31:0] data_i,
   output logic [31:0] data_o
);

   assign data_o = {data_i[7:0], data_i[15:8], data_i[23:16], data_i[31:24]};

endmodule

// File: rtl/miner_header_loader.sv
// Assembles a 20-word (80-byte) block header received over a valid/ready
// stream into the first SHA-256 block, the 96-bit tail and the starting nonce.
// Words are collected in a shadow buffer; a complete header is committed to
// the output registers in a single cycle so the hash pipeline never sees a
// partially updated job.
//
// Build option:
//   MINER_HDR_BSWAP_EN - when defined, each accepted word is byte-reversed
//                        before storage (little-endian host stream to
//                        big-endian SHA-256 words).
//
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   in_data_i        : header word
//   in_sof_i         : marks header word 0
//   in_valid_i       : word valid
//   in_ready_o       : loader can accept a word (low only while a job waits)
//   job_hold_i       : core busy, defers commit of a completed header
//   block1_fixed_o   : header words 0..15, word 0 at [511:480]
//   tail_fixed_o     : header words 16..18, word 16 at [95:64]
//   nonce_start_o    : header word 19
//   job_valid_o      : at least one job committed since reset
//   job_new_o        : one-cycle pulse per commit
//   job_cnt_o        : committed jobs, wrapping
//   sof_err_cnt_o    : framing errors, saturating
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a word with sof; non-sof words are framing errors
// LOAD  | collecting words 1..19 into the shadow buffer
// PEND  | full header held in shadow, waiting for job_hold_i low to commit
module miner_header_loader
   import miner_pkg::*;
#(
   parameter int ERR_W = 8,
   parameter int JOB_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [31:0]        in_data_i,
   input  logic               in_sof_i,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic               job_hold_i,
   output logic [511:0]       block1_fixed_o,
   output logic [95:0]        tail_fixed_o,
   output logic [31:0]        nonce_start_o,
   output logic               job_valid_o,
   output logic               job_new_o,
   output logic [JOB_W-1:0]   job_cnt_o,
   output logic [ERR_W-1:0]   sof_err_cnt_o
);

   loader_state_e                state_q, state_d;
   logic [IDX_W-1:0]             idx_q, idx_d;
   logic [31:0]                  shadow_q [HDR_WORDS];
   logic [31:0]                  shadow_d [HDR_WORDS];
   logic [BLK1_WORDS*32-1:0]     block1_q, block1_d;
   logic [TAIL_WORDS*32-1:0]     tail_q, tail_d;
   logic [31:0]                  nonce_q, nonce_d;
   logic                         job_valid_q, job_valid_d;
   logic                         job_new_q, job_new_d;
   logic [JOB_W-1:0]             job_cnt_q, job_cnt_d;
   logic [ERR_W-1:0]             err_cnt_q, err_cnt_d;

   logic [31:0]                  word_in;
   logic                         accept;

`ifdef MINER_HDR_BSWAP_EN
   miner_bswap32 u_bswap (
      .data_i (in_data_i),
      .data_o (word_in)
   );
`else
   assign word_in = in_data_i;
`endif

   assign in_ready_o = (state_q != PEND);
   assign accept     = in_valid_i && in_ready_o;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      shadow_d    = shadow_q;
      block1_d    = block1_q;
      tail_d      = tail_q;
      nonce_d     = nonce_q;
      job_valid_d = job_valid_q;
      job_new_d   = 1'b0;
      job_cnt_d   = job_cnt_q;
      err_cnt_d   = err_cnt_q;

      case (state_q)
         IDLE: begin
            idx_d = '0;
            if (accept) begin
               if (in_sof_i) begin
                  shadow_d[0] = word_in;
                  idx_d       = IDX_W'(1);
                  state_d     = LOAD;
               end else if (err_cnt_q != '1) begin
                  err_cnt_d = err_cnt_q + ERR_W'(1);
               end
            end
         end

         LOAD: begin
            if (accept) begin
               if (in_sof_i) begin
                  // Truncated header: restart from this word as word 0.
                  if (err_cnt_q != '1) begin
                     err_cnt_d = err_cnt_q + ERR_W'(1);
                  end
                  shadow_d[0] = word_in;
                  idx_d       = IDX_W'(1);
               end else begin
                  shadow_d[idx_q] = word_in;
                  if (idx_q == IDX_W'(NONCE_IDX)) begin
                     idx_d   = '0;
                     state_d = PEND;
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end
            end
         end

         PEND: begin
            if (!job_hold_i) begin
               for (int i = 0; i < BLK1_WORDS; i++) begin
                  block1_d[(BLK1_WORDS-1-i)*32 +: 32] = shadow_q[i];
               end
               for (int i = 0; i < TAIL_WORDS; i++) begin
                  tail_d[(TAIL_WORDS-1-i)*32 +: 32] = shadow_q[BLK1_WORDS+i];
               end
               nonce_d     = shadow_q[NONCE_IDX];
               job_valid_d = 1'b1;
               job_new_d   = 1'b1;
               job_cnt_d   = job_cnt_q + JOB_W'(1);
               state_d     = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         for (int i = 0; i < HDR_WORDS; i++) begin
            shadow_q[i] <= '0;
         end
         block1_q    <= '0;
         tail_q      <= '0;
         nonce_q     <= '0;
         job_valid_q <= 1'b0;
         job_new_q   <= 1'b0;
         job_cnt_q   <= '0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         shadow_q    <= shadow_d;
         block1_q    <= block1_d;
         tail_q      <= tail_d;
         nonce_q     <= nonce_d;
         job_valid_q <= job_valid_d;
         job_new_q   <= job_new_d;
         job_cnt_q   <= job_cnt_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign block1_fixed_o = block1_q;
   assign tail_fixed_o   = tail_q;
   assign nonce_start_o  = nonce_q;
   assign job_valid_o    = job_valid_q;
   assign job_new_o      = job_new_q;
   assign job_cnt_o      = job_cnt_q;
   assign sof_err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_miner_header_loader.sv
// Bench for miner_header_loader: directed scenarios plus randomized header
// traffic, every cycle compared against a queue-based reference model.
module tb_miner_header_loader;

   localparam int ERR_W = 8;
   localparam int JOB_W = 16;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [31:0]        in_data_i = '0;
   logic               in_sof_i = 1'b0;
   logic               in_valid_i = 1'b0;
   logic               in_ready_o;
   logic               job_hold_i = 1'b0;
   logic [511:0]       block1_fixed_o;
   logic [95:0]        tail_fixed_o;
   logic [31:0]        nonce_start_o;
   logic               job_valid_o;
   logic               job_new_o;
   logic [JOB_W-1:0]   job_cnt_o;
   logic [ERR_W-1:0]   sof_err_cnt_o;

   miner_header_loader #(.ERR_W(ERR_W), .JOB_W(JOB_W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_data_i      (in_data_i),
      .in_sof_i       (in_sof_i),
      .in_valid_i     (in_valid_i),
      .in_ready_o     (in_ready_o),
      .job_hold_i     (job_hold_i),
      .block1_fixed_o (block1_fixed_o),
      .tail_fixed_o   (tail_fixed_o),
      .nonce_start_o  (nonce_start_o),
      .job_valid_o    (job_valid_o),
      .job_new_o      (job_new_o),
      .job_cnt_o      (job_cnt_o),
      .sof_err_cnt_o  (sof_err_cnt_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // reference model: header in progress is just a queue of stored words
   logic [31:0]       m_part [$];
   logic              m_pend;
   logic [511:0]      m_blk;
   logic [95:0]       m_tail;
   logic [31:0]       m_nonce;
   logic              m_valid;
   logic              m_new;
   int unsigned       m_cnt;
   int unsigned       m_err;

   function automatic logic [31:0] xf(input logic [31:0] w);
`ifdef MINER_HDR_BSWAP_EN
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
      return w;
`endif
   endfunction

   task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_part.delete();
      m_pend  = 1'b0;
      m_blk   = '0;
      m_tail  = '0;
      m_nonce = '0;
      m_valid = 1'b0;
      m_new   = 1'b0;
      m_cnt   = 0;
      m_err   = 0;
   endtask

   task automatic model_err();
      if (m_err < (1 << ERR_W) - 1) m_err++;
   endtask

   task automatic model_edge(input logic v, input logic s, input logic [31:0] d, input logic h);
      logic [31:0] w;
      m_new = 1'b0;
      if (m_pend) begin
         if (!h) begin
            for (int i = 0; i < 16; i++) m_blk[511-32*i -: 32] = m_part[i];
            m_tail  = {m_part[16], m_part[17], m_part[18]};
            m_nonce = m_part[19];
            m_part.delete();
            m_pend  = 1'b0;
            m_valid = 1'b1;
            m_new   = 1'b1;
            m_cnt   = (m_cnt + 1) % (1 << JOB_W);
         end
      end else if (v) begin
         w = xf(d);
         if (s) begin
            if (m_part.size() != 0) model_err();
            m_part.delete();
            m_part.push_back(w);
         end else if (m_part.size() == 0) begin
            model_err();
         end else begin
            m_part.push_back(w);
         end
         if (m_part.size() == 20) m_pend = 1'b1;
      end
   endtask

   task automatic check_outputs();
      check_eq("block1", block1_fixed_o, m_blk);
      check_eq("tail", tail_fixed_o, m_tail);
      check_eq("nonce", nonce_start_o, m_nonce);
      check_eq("job_valid", job_valid_o, m_valid);
      check_eq("job_new", job_new_o, m_new);
      check_eq("job_cnt", job_cnt_o, JOB_W'(m_cnt));
      check_eq("sof_err", sof_err_cnt_o, ERR_W'(m_err));
   endtask

   // one clock: drive inputs, check ready, advance model, check outputs
   task automatic step(input logic v, input logic s, input logic [31:0] d, input logic h);
      in_valid_i = v;
      in_sof_i   = s;
      in_data_i  = d;
      job_hold_i = h;
      #1;
      check_eq("ready", in_ready_o, !m_pend);
      model_edge(v, s, d, h);
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic send_word(input logic [31:0] d, input logic s, input int hold_pct);
      bit acc;
      int n;
      n = 0;
      do begin
         acc = !m_pend;
         step(1'b1, s, d, ($urandom_range(99) < hold_pct));
         n++;
      end while (!acc && n < 200);
      if (!acc) begin
         n_checks++;
         n_errors++;
         $display("FAIL accept_timeout got=not_accepted exp=accepted @%0t", $time);
      end
      in_valid_i = 1'b0;
   endtask

   task automatic idle(input int n, input logic h);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, $urandom, h);
   endtask

   task automatic do_reset();
      in_valid_i = 1'b0;
      job_hold_i = 1'b0;
      rst_n = 1'b0;
      model_reset();
      #2;
      check_outputs();
      check_eq("ready_rst", in_ready_o, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      model_reset();
      #3;
      do_reset();
      check_outputs();

      // normal load 0..19
      for (int i = 0; i < 20; i++) send_word(32'(i), (i == 0), 0);
      idle(1, 1'b0);
      check_eq("n_blk_w0", block1_fixed_o[511:480], xf(32'h0));
      check_eq("n_blk_w15", block1_fixed_o[31:0], xf(32'hF));
      check_eq("n_tail", tail_fixed_o, {xf(32'h10), xf(32'h11), xf(32'h12)});
      check_eq("n_nonce", nonce_start_o, xf(32'h13));
      check_eq("n_cnt", job_cnt_o, 16'd1);
      idle(2, 1'b0);

      // hold across PEND for 10 cycles
      for (int i = 0; i < 19; i++) send_word(32'h100 + 32'(i), (i == 0), 0);
      step(1'b1, 1'b0, 32'h113, 1'b1);
      idle(10, 1'b1);
      check_eq("h_old_nonce", nonce_start_o, xf(32'h13));
      idle(1, 1'b0);
      check_eq("h_new_nonce", nonce_start_o, xf(32'h113));
      check_eq("h_cnt", job_cnt_o, 16'd2);
      idle(2, 1'b0);

      // framing: 3 stray words, sof at idx 7, then a full header from it
      for (int i = 0; i < 3; i++) send_word($urandom, 1'b0, 0);
      for (int i = 0; i < 7; i++) send_word(32'h200 + 32'(i), (i == 0), 0);
      for (int i = 0; i < 20; i++) send_word(32'h300 + 32'(i), (i == 0), 0);
      idle(1, 1'b0);
      check_eq("f_err", sof_err_cnt_o, 8'd4);
      check_eq("f_blk_w0", block1_fixed_o[511:480], xf(32'h300));
      check_eq("f_nonce", nonce_start_o, xf(32'h313));

`ifdef MINER_HDR_BSWAP_EN
      send_word(32'h01020304, 1'b1, 0);
      for (int i = 1; i < 20; i++) send_word($urandom, 1'b0, 0);
      idle(1, 1'b0);
      check_eq("bswap_w0", block1_fixed_o[511:480], 32'h04030201);
`endif

      // randomized traffic: gaps, holds, occasional stray sof / missing sof
      for (int hdr = 0; hdr < 25; hdr++) begin
         for (int i = 0; i < 20; i++) begin
            logic s;
            s = (i == 0);
            if ($urandom_range(59) == 0) s = ~s;
            if ($urandom_range(2) == 0) idle($urandom_range(2), $urandom_range(1));
            send_word($urandom, s, 30);
         end
      end
      idle(3, 1'b0);

      // reset mid-load at idx 12 after a committed job
      for (int i = 0; i < 20; i++) send_word($urandom, (i == 0), 0);
      idle(1, 1'b0);
      for (int i = 0; i < 12; i++) send_word($urandom, (i == 0), 0);
      @(negedge clk);
      do_reset();
      check_eq("r_valid", job_valid_o, 1'b0);
      check_eq("r_nonce", nonce_start_o, 32'h0);
      for (int i = 0; i < 20; i++) send_word(32'h500 + 32'(i), (i == 0), 0);
      idle(1, 1'b0);
      check_eq("r_cnt", job_cnt_o, 16'd1);
      check_eq("r_nonce2", nonce_start_o, xf(32'h513));

      // error counter saturation
      for (int i = 0; i < 260; i++) send_word($urandom, 1'b0, 0);
      check_eq("sat_err", sof_err_cnt_o, 8'hFF);
      idle(2, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
